// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and the
// elaboration-time legality check for the WIDTH/STAGES pair.
package pipelined_adder_pkg;

  // Bits consumed per pipeline stage; a zero stage count is reported by
  // stages_ok, so it is mapped to a harmless value here to avoid a divide by zero.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    if (stages == 0) return width;
    return width / stages;
  endfunction

  // True when the operand splits into STAGES equal, non-empty chunks.
  function automatic bit stages_ok(input int unsigned width,
                                   input int unsigned stages);
    if (width < 1) return 1'b0;
    if (stages < 1) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage of the pipelined adder.
// Adds chunk IDX of the operands plus the incoming carry, and registers the
// valid bit, the chunk carry, the sum bits produced so far and the operand
// bits not yet consumed.
// Optional feature macro: PIPELINED_ADDER_OVF_EN (adds the ovf register).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load               stage may capture this cycle (its ready)
//   valid_in           upstream valid
//   carry_in           carry from the previous stage (c_in for stage 0)
//   a_in, b_in         operand bits still in flight (consumed bits are zero)
//   sum_in             sum bits produced by earlier stages
//   valid, carry       registered valid and chunk carry
//   a_out, b_out       registered operands with this chunk cleared
//   sum_out            registered partial sum including this chunk
//   ovf                registered signed overflow of this chunk's top bit
module pipelined_adder_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             valid_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic             valid,
  output logic             carry,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum_out
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned LO = IDX * CHUNK;
  localparam int unsigned HI = LO + CHUNK;
  // Bits below HI have been consumed once this stage has added its chunk.
  localparam logic [WIDTH-1:0] DONE_MASK = {WIDTH{1'b1}} >> (WIDTH - HI);

  logic [CHUNK:0]     chunk_res;
  logic [WIDTH-1:0]   sum_next;
  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   b_next;

  // Chunk add with carry-out in the MSB.
  assign chunk_res = {1'b0, a_in[LO +: CHUNK]} + {1'b0, b_in[LO +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_in};
  assign sum_next  = sum_in | (WIDTH'(chunk_res[CHUNK-1:0]) << LO);
  // Consumed chunks are cleared rather than carried down the pipe.
  assign a_next    = a_in & ~DONE_MASK;
  assign b_next    = b_in & ~DONE_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      carry   <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
      sum_out <= '0;
    end else if (load) begin
      valid <= valid_in;
      if (valid_in) begin
        carry   <= chunk_res[CHUNK];
        a_out   <= a_next;
        b_out   <= b_next;
        sum_out <= sum_next;
      end
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  // Carry into the chunk's top bit is a^b^s there; XOR with the carry out.
  logic ovf_next;
  assign ovf_next = a_in[HI-1] ^ b_in[HI-1] ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (load && valid_in) begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: sum = (a + b + c_in) mod 2^WIDTH with the
// true carry-out, produced STAGES cycles after acceptance. Valid/ready on
// both sides with full backpressure, one transaction per cycle.
// Optional feature macro: PIPELINED_ADDER_OVF_EN (adds the ovf output).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid, in_ready     input handshake (in_ready is combinational)
//   a, b, c_in             operands and carry-in
//   out_valid, out_ready   output handshake
//   sum, c_out             result and carry out of bit WIDTH-1
//   ovf                    signed overflow (only with PIPELINED_ADDER_OVF_EN)
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!stages_ok(WIDTH, STAGES)) begin : g_cfg_err
    $fatal(1, "pipelined_adder: STAGES must be >= 1 and divide WIDTH");
  end

  // Index 0 is the input side; index k+1 holds the registers of stage k.
  logic [STAGES:0] vld;
  logic [STAGES:0] cry;
  logic [STAGES:0] rdy;
  logic [WIDTH-1:0] a_p [STAGES+1];
  logic [WIDTH-1:0] b_p [STAGES+1];
  logic [WIDTH-1:0] s_p [STAGES+1];
`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_s [STAGES];
`endif

  assign vld[0] = in_valid;
  assign cry[0] = c_in;
  assign a_p[0] = a;
  assign b_p[0] = b;
  assign s_p[0] = '0;

  // Ready ripples back from the consumer; an empty stage is always ready.
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign rdy[k] = !vld[k+1] || rdy[k+1];

    pipelined_adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rdy[k]),
      .valid_in (vld[k]),
      .carry_in (cry[k]),
      .a_in     (a_p[k]),
      .b_in     (b_p[k]),
      .sum_in   (s_p[k]),
      .valid    (vld[k+1]),
      .carry    (cry[k+1]),
      .a_out    (a_p[k+1]),
      .b_out    (b_p[k+1]),
      .sum_out  (s_p[k+1])
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf      (ovf_s[k])
`endif
    );
  end

  // Results come straight from the last stage's registers.
  assign out_valid = vld[STAGES];
  assign sum       = s_p[STAGES];
  assign c_out     = cry[STAGES];
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = ovf_s[STAGES-1];
`endif

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder that adds two WIDTH-bit operands plus carry-in and returns sum and carry-out after STAGES clock cycles. Operands are split into STAGES equal chunks, one chunk added per stage, with the chunk carry registered between stages. It has valid/ready handshakes on both sides, supports full backpressure and accepts one transaction per cycle. It is the next generation of the team's combinational 4-bit full adder, intended for datapaths where wide additions must meet timing.

## Interface
- WIDTH, 32: operand and sum width in bits; must be at least 1.
- STAGES, 4: number of pipeline stages, which is also the latency. Must be at least 1 and divide WIDTH exactly.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  pipeline can accept a transaction this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow. Present only with PIPELINED_ADDER_OVF_EN.

## Operation
- CHUNK = WIDTH/STAGES.
- Stage k adds bits [k*CHUNK +: CHUNK] of a and b, plus the carry registered from stage k-1. Stage 0 uses c_in instead.
- Each stage registers:
  - its valid bit,
  - its chunk carry,
  - the sum bits computed so far,
  - the operand chunks not yet consumed.
- Operand chunks that have been consumed are dropped.
- Ready chain, purely combinational:
  - ready_k = !valid_k || ready_{k+1}
  - ready_STAGES = out_ready
  - in_ready = ready_0
- Stage k loads when ready_k is high:
  - valid_k takes valid_{k-1}; valid_{-1} = in_valid.
  - Data registers load only when the incoming valid is 1.
- A transfer happens on any edge where valid and ready are both 1.
- Results leave in acceptance order; transactions are never dropped or duplicated.
- sum, c_out and ovf come straight from the last stage's registers.
  - They are held stable while out_valid=1 && out_ready=0.
  - They are don't-care while out_valid=0.
- Arithmetic is unsigned modulo 2^WIDTH; c_out is the true carry.
- STAGES=1 degenerates to a single registered adder with the same handshake.

## Timing
- Reset (async assert, sync deassert handled outside): every valid bit is 0 and every data register is 0. Outputs: out_valid=0, sum=0, c_out=0, ovf=0. in_ready=1 while rst_n is high.
- Latency: a transaction accepted at edge N shows out_valid=1 after edge N+STAGES-1, i.e. it is visible in cycle N+STAGES, when there are no stalls.
- Throughput: 1 transaction/cycle while out_ready=1.
- Stall with out_ready=0:
  - The bubbles collapse first.
  - in_ready falls once all STAGES registers hold valid data.
  - At most STAGES transactions are held.
- Full pipeline with out_ready and in_valid both 1: accept and retire happen in the same cycle (no bubble).
- Reset asserted mid-operation: all in-flight transactions are discarded immediately. out_valid falls asynchronously.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.

## Configuration
- PIPELINED_ADDER_OVF_EN defined:
  - ovf port exists.
  - ovf = carry into bit WIDTH-1 XOR c_out, computed in the last stage and registered with sum.
  - ovf resets to 0.
- PIPELINED_ADDER_OVF_EN undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package pipelined_adder_pkg holds:
  - a function computing CHUNK,
  - an elaboration-time check function for WIDTH%STAGES==0 and STAGES>=1. A violation is a $fatal at elaboration.
- Sub-module pipelined_adder_stage is one CHUNK-bit add plus valid/carry/data registers. It is instantiated STAGES times in a generate loop.
- The top level contains the ready chain and the output mapping.

## Test plan
All scenarios use WIDTH=8, STAGES=2 with out_ready=1 unless stated.
- 0x2A + 0x14, c_in=0 -> sum=0x3E, c_out=0; out_valid rises exactly 2 cycles after acceptance.
- 0xFF + 0x01, c_in=0 -> sum=0x00, c_out=1 (carry crosses the stage boundary). 0x0F + 0x00, c_in=1 -> sum=0x10, c_out=0.
- Back-to-back stream 0x01+0x01, 0x02+0x02, ..., 0x08+0x08 with in_valid held high:
  - in_ready stays 1 throughout.
  - Results 0x02, 0x04, ..., 0x10 arrive on consecutive cycles.
- Backpressure: out_ready=0 for 6 cycles while offering 4 transactions.
  - Exactly 2 are accepted, then in_ready=0.
  - sum holds its first value.
  - After out_ready=1, all 4 results emerge in order with none lost.
- Reset asserted with 2 transactions in flight:
  - out_valid=0, sum=0, c_out=0 immediately.
  - After release, in_ready=1 and no stale result appears.
- With PIPELINED_ADDER_OVF_EN:
  - 0x7F + 0x01 -> sum=0x80, ovf=1, c_out=0.
  - 0x80 + 0x80 -> sum=0x00, ovf=1, c_out=1.
  - 0xFF + 0x01 -> ovf=0.
